// File: rtl/lift_pkg.sv
// Shared types and motor encodings for the lift car controller.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DN,
    ST_DOOR_OPEN
  } lift_state_t;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DN   = 2'b10;

endpackage

// File: rtl/lift_car_ctrl_if.sv
// Request inputs and status outputs of one lift car.
interface lift_car_ctrl_if #(
  parameter int N_FLOORS = 11,
  parameter int FW       = $clog2(N_FLOORS)
);

  logic [N_FLOORS-1:0] car_req;
  logic [N_FLOORS-1:0] hall_up;
  logic [N_FLOORS-1:0] hall_dn;
  logic                door_hold;
  logic [1:0]          motor_signal;
  logic [FW-1:0]       cur_floor;
  logic                door_open;
  logic                dir_up;
  logic                busy;

  modport master (
    output car_req, hall_up, hall_dn, door_hold,
    input  motor_signal, cur_floor, door_open, dir_up, busy
  );

  modport slave (
    input  car_req, hall_up, hall_dn, door_hold,
    output motor_signal, cur_floor, door_open, dir_up, busy
  );

endinterface

// File: rtl/lift_req_bank.sv
// Pending car/hall request registers, one bit per floor; clear beats set.
// Also reports what is pending at, above and below a query floor.
module lift_req_bank #(
  parameter int N_FLOORS = 11,
  parameter int FW       = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] set_car,
  input  logic [N_FLOORS-1:0] set_up,
  input  logic [N_FLOORS-1:0] set_dn,
  input  logic [N_FLOORS-1:0] clr_car,
  input  logic [N_FLOORS-1:0] clr_up,
  input  logic [N_FLOORS-1:0] clr_dn,
  input  logic [FW-1:0]       floor,
  output logic                here_car,
  output logic                here_up,
  output logic                here_dn,
  output logic                above,
  output logic                below,
  output logic                any_pend
);

  logic [N_FLOORS-1:0] car_pend;
  logic [N_FLOORS-1:0] up_pend;
  logic [N_FLOORS-1:0] dn_pend;
  logic [N_FLOORS-1:0] all_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_pend <= '0;
      up_pend  <= '0;
      dn_pend  <= '0;
    end else begin
      car_pend <= (car_pend | set_car) & ~clr_car;
      up_pend  <= (up_pend  | set_up)  & ~clr_up;
      dn_pend  <= (dn_pend  | set_dn)  & ~clr_dn;
    end
  end

  assign all_pend = car_pend | up_pend | dn_pend;
  assign any_pend = |all_pend;
  assign here_car = car_pend[floor];
  assign here_up  = up_pend[floor];
  assign here_dn  = dn_pend[floor];

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(floor)) above = above | all_pend[i];
      if (i < int'(floor)) below = below | all_pend[i];
    end
  end

endmodule

// File: rtl/lift_car_ctrl.sv
// Single-car collective (SCAN) elevator controller: sweeps one direction while
// requests remain ahead, stopping at matching floors; times travel and door dwell.
module lift_car_ctrl #(
  parameter int N_FLOORS      = 11,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input logic            clk,
  input logic            rst,
  lift_car_ctrl_if.slave bus
);

  import lift_pkg::*;

  localparam int FW = $clog2(N_FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [N_FLOORS-1:0] UP_OK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_OK = {{(N_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);

  lift_state_t         state, state_nxt;
  logic [FW-1:0]       cur_floor, floor_nxt, eval_floor;
  logic                dir_up, dir_nxt;
  logic [TW-1:0]       travel_cnt, travel_nxt;
  logic [DW-1:0]       door_cnt, door_nxt;
  logic [N_FLOORS-1:0] set_car, set_up, set_dn;
  logic [N_FLOORS-1:0] clr_car, clr_up, clr_dn;
  logic [N_FLOORS-1:0] floor_oh;
  logic                here_car, here_up, here_dn, above, below, any_pend;
  logic                travel_last, door_last, here_any, absorb, stop_up, stop_dn;

  assign set_car     = bus.car_req;
  assign set_up      = bus.hall_up & UP_OK;
  assign set_dn      = bus.hall_dn & DN_OK;
  assign travel_last = (travel_cnt == TW'(TRAVEL_CYCLES - 1));
  assign door_last   = (door_cnt == DW'(DOOR_CYCLES - 1));

  // On a hop edge all request queries refer to the floor being arrived at.
  always_comb begin
    eval_floor = cur_floor;
    if (state == ST_MOVE_UP && travel_last)
      eval_floor = cur_floor + FW'(1);
    else if (state == ST_MOVE_DN && travel_last)
      eval_floor = cur_floor - FW'(1);
  end

  assign floor_oh = {{(N_FLOORS-1){1'b0}}, 1'b1} << eval_floor;
  assign here_any = here_car | here_up | here_dn;
  assign absorb   = |(floor_oh & (set_car | set_up | set_dn));
  assign stop_up  = here_car | here_up | (!above && here_dn) | (eval_floor == TOP_FLOOR);
  assign stop_dn  = here_car | here_dn | (!below && here_up) | (eval_floor == '0);

  lift_req_bank #(.N_FLOORS(N_FLOORS)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .set_car (set_car),
    .set_up  (set_up),
    .set_dn  (set_dn),
    .clr_car (clr_car),
    .clr_up  (clr_up),
    .clr_dn  (clr_dn),
    .floor   (eval_floor),
    .here_car(here_car),
    .here_up (here_up),
    .here_dn (here_dn),
    .above   (above),
    .below   (below),
    .any_pend(any_pend)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cur_floor  <= floor_nxt;
      dir_up     <= dir_nxt;
      travel_cnt <= travel_nxt;
      door_cnt   <= door_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    floor_nxt  = cur_floor;
    dir_nxt    = dir_up;
    travel_nxt = travel_cnt;
    door_nxt   = door_cnt;
    clr_car    = '0;
    clr_up     = '0;
    clr_dn     = '0;
    case (state)
      ST_IDLE: begin
        travel_nxt = '0;
        door_nxt   = '0;
        if (here_any) begin
          state_nxt = ST_DOOR_OPEN;
          clr_car   = floor_oh;
          clr_up    = floor_oh;
          clr_dn    = floor_oh;
        end else if (above && (dir_up || !below)) begin
          state_nxt = ST_MOVE_UP;
          dir_nxt   = 1'b1;
        end else if (below) begin
          state_nxt = ST_MOVE_DN;
          dir_nxt   = 1'b0;
        end
      end
      ST_MOVE_UP: begin
        if (travel_last) begin
          travel_nxt = '0;
          floor_nxt  = eval_floor;
          if (stop_up) begin
            state_nxt = ST_DOOR_OPEN;
            clr_car   = floor_oh;
            clr_up    = floor_oh;
            if (!above) begin
              clr_dn = floor_oh;
              if (here_dn) dir_nxt = 1'b0;
            end
          end
        end else begin
          travel_nxt = travel_cnt + TW'(1);
        end
      end
      ST_MOVE_DN: begin
        if (travel_last) begin
          travel_nxt = '0;
          floor_nxt  = eval_floor;
          if (stop_dn) begin
            state_nxt = ST_DOOR_OPEN;
            clr_car   = floor_oh;
            clr_dn    = floor_oh;
            if (!below) begin
              clr_up = floor_oh;
              if (here_up) dir_nxt = 1'b1;
            end
          end
        end else begin
          travel_nxt = travel_cnt + TW'(1);
        end
      end
      ST_DOOR_OPEN: begin
        // A fresh request for this floor is served by the open door.
        clr_car = floor_oh & set_car;
        clr_up  = floor_oh & set_up;
        clr_dn  = floor_oh & set_dn;
        if (bus.door_hold || absorb) begin
          door_nxt = '0;
        end else if (door_last) begin
          door_nxt  = '0;
          state_nxt = ST_IDLE;
        end else begin
          door_nxt = door_cnt + DW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.motor_signal = (state == ST_MOVE_UP) ? MOTOR_UP :
                            (state == ST_MOVE_DN) ? MOTOR_DN : MOTOR_STOP;
  assign bus.cur_floor    = cur_floor;
  assign bus.door_open    = (state == ST_DOOR_OPEN);
  assign bus.dir_up       = dir_up;
  assign bus.busy         = any_pend || (state != ST_IDLE);

endmodule
